// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 receive sequencer.
// Holds the frame FSM encoding, the prefix bytes and the key-event payload.
package ps2_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_DATA   = 3'd1,
        ST_PARITY = 3'd2,
        ST_STOP   = 3'd3,
        ST_DECODE = 3'd4
    } ps2_state_e;

    localparam logic [7:0] PS2_EXT_PREFIX   = 8'hE0;
    localparam logic [7:0] PS2_BREAK_PREFIX = 8'hF0;
    localparam int         PS2_DATA_BITS    = 8;

    typedef struct packed {
        logic [7:0] code;
        logic       ext;
        logic       brk;
    } key_event_t;

    // PS/2 uses odd parity: data bits plus parity bit must hold an odd number of ones.
    function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
        return ^{data, par};
    endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// Synchronizes the raw PS/2 lines and glitch-filters PS2Clk, producing a
// one-cycle strobe on every filtered falling edge plus a synchronized data bit.
module ps2_line_filter #(
    parameter int FILTER_LEN = 4
) (
    input  logic clk,
    input  logic rstn,
    input  logic ps2_clk_in,
    input  logic ps2_data_in,
    output logic strobe,
    output logic data_sync
);

    localparam int CNT_W = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_LEN - 1);

    logic             clk_meta_r;
    logic             clk_sync_r;
    logic             data_meta_r;
    logic             data_sync_r;
    logic             clk_filt_r;
    logic [CNT_W-1:0] cnt_r;
    logic             strobe_r;
    logic             differ_s;
    logic             settle_s;

    assign differ_s  = (clk_sync_r != clk_filt_r);
    assign settle_s  = differ_s && (cnt_r == CNT_LAST);
    assign strobe    = strobe_r;
    assign data_sync = data_sync_r;

    // Two-flop synchronizers; the bus idles high so both reset to 1.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            clk_meta_r  <= 1'b1;
            clk_sync_r  <= 1'b1;
            data_meta_r <= 1'b1;
            data_sync_r <= 1'b1;
        end else begin
            clk_meta_r  <= ps2_clk_in;
            clk_sync_r  <= clk_meta_r;
            data_meta_r <= ps2_data_in;
            data_sync_r <= data_meta_r;
        end
    end

    // Filtered clock follows only after FILTER_LEN differing samples in a row.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            clk_filt_r <= 1'b1;
            cnt_r      <= '0;
            strobe_r   <= 1'b0;
        end else begin
            strobe_r <= settle_s && clk_filt_r;
            if (!differ_s || settle_s) begin
                cnt_r <= '0;
            end else begin
                cnt_r <= cnt_r + CNT_W'(1);
            end
            if (settle_s) begin
                clk_filt_r <= clk_sync_r;
            end
        end
    end

endmodule

// File: rtl/ps2_rx_sequencer.sv
// PS/2 keyboard frame receiver: walks start/data/parity/stop, folds E0/F0
// prefixes into one key event and hands it over through a one-entry register.
module ps2_rx_sequencer
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN     = 4,
    parameter int TIMEOUT_CYCLES = 200000
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ev_valid,
    input  logic       ev_ready,
    output logic [7:0] ev_code,
    output logic       ev_ext,
    output logic       ev_break,
    output logic       err_parity,
    output logic       err_frame,
    output logic       err_overrun,
    output logic       busy
);

    localparam int WD_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

    logic             strobe_s;
    logic             data_s;
    ps2_state_e       state_r, state_s;
    logic [2:0]       bit_cnt_r, bit_cnt_s;
    logic [7:0]       shift_r, shift_s;
    logic             par_r, par_s;
    logic             ext_r, ext_s;
    logic             brk_r, brk_s;
    logic [WD_W-1:0]  wd_r, wd_s;
    logic             timeout_s;
    logic             emit_s;
    logic             err_parity_s;
    logic             err_frame_s;
    key_event_t       ev_r;
    logic             ev_valid_r;
    logic             err_parity_r;
    logic             err_frame_r;
    logic             err_overrun_r;
    logic             busy_r;

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_line_filter (
        .clk         (clk),
        .rstn        (rstn),
        .ps2_clk_in  (ps2_clk_in),
        .ps2_data_in (ps2_data_in),
        .strobe      (strobe_s),
        .data_sync   (data_s)
    );

    assign timeout_s = (state_r != ST_IDLE) && !strobe_s && (wd_r == WD_LAST);

    // Frame FSM next-state, datapath updates and error decisions.
    always_comb begin
        state_s      = state_r;
        bit_cnt_s    = bit_cnt_r;
        shift_s      = shift_r;
        par_s        = par_r;
        ext_s        = ext_r;
        brk_s        = brk_r;
        emit_s       = 1'b0;
        err_parity_s = 1'b0;
        err_frame_s  = 1'b0;
        if ((state_r == ST_IDLE) || strobe_s) begin
            wd_s = '0;
        end else begin
            wd_s = wd_r + WD_W'(1);
        end
        case (state_r)
            ST_IDLE: begin
                if (strobe_s && !data_s) begin
                    state_s   = ST_DATA;
                    bit_cnt_s = 3'd0;
                end else begin
                    err_frame_s = strobe_s;
                end
            end
            ST_DATA: begin
                if (strobe_s) begin
                    shift_s   = {data_s, shift_r[7:1]};
                    bit_cnt_s = bit_cnt_r + 3'd1;
                    state_s   = (bit_cnt_r == 3'(PS2_DATA_BITS - 1)) ? ST_PARITY : ST_DATA;
                end else begin
                    state_s = ST_DATA;
                end
            end
            ST_PARITY: begin
                if (strobe_s) begin
                    par_s   = data_s;
                    state_s = ST_STOP;
                end else begin
                    state_s = ST_PARITY;
                end
            end
            ST_STOP: begin
                if (strobe_s) begin
                    err_parity_s = !odd_parity_ok(shift_r, par_r);
                    err_frame_s  = odd_parity_ok(shift_r, par_r) && !data_s;
                    if (err_parity_s || err_frame_s) begin
                        state_s = ST_IDLE;
                        shift_s = 8'h00;
                        ext_s   = 1'b0;
                        brk_s   = 1'b0;
                    end else begin
                        state_s = ST_DECODE;
                    end
                end else begin
                    state_s = ST_STOP;
                end
            end
            ST_DECODE: begin
                state_s = ST_IDLE;
                if (shift_r == PS2_EXT_PREFIX) begin
                    ext_s = 1'b1;
                end else if (shift_r == PS2_BREAK_PREFIX) begin
                    brk_s = 1'b1;
                end else begin
                    emit_s = 1'b1;
                    ext_s  = 1'b0;
                    brk_s  = 1'b0;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
        // A stalled frame is abandoned wholesale, prefixes included.
        if (timeout_s) begin
            state_s     = ST_IDLE;
            bit_cnt_s   = 3'd0;
            shift_s     = 8'h00;
            ext_s       = 1'b0;
            brk_s       = 1'b0;
            emit_s      = 1'b0;
            err_frame_s = 1'b1;
            wd_s        = '0;
        end else begin
            wd_s = wd_s;
        end
    end

    // Frame state, datapath and registered status outputs.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r      <= ST_IDLE;
            bit_cnt_r    <= 3'd0;
            shift_r      <= 8'h00;
            par_r        <= 1'b0;
            ext_r        <= 1'b0;
            brk_r        <= 1'b0;
            wd_r         <= '0;
            err_parity_r <= 1'b0;
            err_frame_r  <= 1'b0;
            busy_r       <= 1'b0;
        end else begin
            state_r      <= state_s;
            bit_cnt_r    <= bit_cnt_s;
            shift_r      <= shift_s;
            par_r        <= par_s;
            ext_r        <= ext_s;
            brk_r        <= brk_s;
            wd_r         <= wd_s;
            err_parity_r <= err_parity_s;
            err_frame_r  <= err_frame_s;
            busy_r       <= (state_s != ST_IDLE);
        end
    end

    // One-entry holding register: pop and reload may coincide; a full, unpopped slot drops the newcomer.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ev_r          <= '0;
            ev_valid_r    <= 1'b0;
            err_overrun_r <= 1'b0;
        end else begin
            err_overrun_r <= 1'b0;
            if (ev_valid_r && ev_ready) begin
                ev_valid_r <= 1'b0;
            end
            if (emit_s) begin
                if (!ev_valid_r || ev_ready) begin
                    ev_r.code  <= shift_r;
                    ev_r.ext   <= ext_r;
                    ev_r.brk   <= brk_r;
                    ev_valid_r <= 1'b1;
                end else begin
                    err_overrun_r <= 1'b1;
                end
            end
        end
    end

    assign ev_valid    = ev_valid_r;
    assign ev_code     = ev_r.code;
    assign ev_ext      = ev_r.ext;
    assign ev_break    = ev_r.brk;
    assign err_parity  = err_parity_r;
    assign err_frame   = err_frame_r;
    assign err_overrun = err_overrun_r;
    assign busy        = busy_r;

endmodule

// File: tb/tb_ps2_rx_sequencer.sv
// Scoreboard bench for ps2_rx_sequencer: directed PS/2 frames are bit-banged in,
// expected key events are queued, and a negedge monitor pops them on each handshake.
module tb_ps2_rx_sequencer;

    localparam int FILT = 4;
    localparam int TO   = 100;
    localparam int HALF = 12;

    typedef struct packed {
        logic [7:0] code;
        logic       ext;
        logic       brk;
    } exp_t;

    logic       clk = 1'b0;
    logic       rstn = 1'b1;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic       ev_ready = 1'b0;
    logic       ev_valid;
    logic [7:0] ev_code;
    logic       ev_ext;
    logic       ev_break;
    logic       err_parity;
    logic       err_frame;
    logic       err_overrun;
    logic       busy;

    exp_t q[$];
    int n_vec = 0;
    int n_err = 0;
    int n_par = 0;
    int n_frm = 0;
    int n_ovr = 0;
    int n_valid = 0;

    ps2_rx_sequencer #(.FILTER_LEN(FILT), .TIMEOUT_CYCLES(TO)) dut (
        .clk         (clk),
        .rstn        (rstn),
        .ps2_clk_in  (ps2_clk),
        .ps2_data_in (ps2_data),
        .ev_valid    (ev_valid),
        .ev_ready    (ev_ready),
        .ev_code     (ev_code),
        .ev_ext      (ev_ext),
        .ev_break    (ev_break),
        .err_parity  (err_parity),
        .err_frame   (err_frame),
        .err_overrun (err_overrun),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard on every accepted event and tallies pulses.
    always @(negedge clk) begin
        if (rstn) begin
            if (ev_valid) n_valid++;
            if (err_parity) n_par++;
            if (err_frame) n_frm++;
            if (err_overrun) n_ovr++;
            if (ev_valid && ev_ready) begin
                if (q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_event: got code 0x%0h ext %0b brk %0b, expected none",
                             ev_code, ev_ext, ev_break);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    check("event", {22'd0, ev_code, ev_ext, ev_break}, {22'd0, e.code, e.ext, e.brk});
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] code, input logic ext, input logic brk);
        exp_t e;
        e.code = code;
        e.ext  = ext;
        e.brk  = brk;
        q.push_back(e);
    endtask

    task automatic send_bit(input logic b, input bit glitch);
        ps2_data = b;
        tick(HALF);
        ps2_clk = 1'b0;
        tick(HALF);
        ps2_clk = 1'b1;
        if (glitch) begin
            tick(8);
            ps2_clk = 1'b0;
            tick(FILT - 1);
            ps2_clk = 1'b1;
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input bit bad_par, input int glitch_bit, input int nbits);
        logic [10:0] fr;
        fr = {1'b1, (~^b) ^ bad_par, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            send_bit(fr[i], i == glitch_bit);
        end
        ps2_data = 1'b1;
        if (nbits == 11) tick(2 * HALF);
    endtask

    initial begin
        #1 rstn = 1'b0;
        tick(3);
        check("reset_ev_valid", {31'd0, ev_valid}, 32'd0);
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_errors", {29'd0, err_parity, err_frame, err_overrun}, 32'd0);
        check("reset_payload", {22'd0, ev_code, ev_ext, ev_break}, 32'd0);
        rstn = 1'b1;
        tick(5);

        // Plain make code, consumer always ready.
        ev_ready = 1'b1;
        n_valid  = 0;
        push(8'h1C, 1'b0, 1'b0);
        send_frame(8'h1C, 1'b0, -1, 11);
        tick(10);
        check("single_valid_cycles", n_valid, 32'd1);
        check("single_no_errors", n_par + n_frm + n_ovr, 32'd0);

        // Break and extended-break sequences collapse to one event each.
        push(8'h1C, 1'b0, 1'b1);
        send_frame(8'hF0, 1'b0, -1, 11);
        send_frame(8'h1C, 1'b0, -1, 11);
        push(8'h75, 1'b1, 1'b1);
        send_frame(8'hE0, 1'b0, -1, 11);
        send_frame(8'hF0, 1'b0, -1, 11);
        send_frame(8'h75, 1'b0, -1, 11);
        tick(10);

        // Parity failure, then a clean extended code.
        send_frame(8'h1C, 1'b1, -1, 11);
        tick(10);
        check("parity_pulse", n_par, 32'd1);
        check("parity_no_frame_err", n_frm, 32'd0);
        push(8'h74, 1'b1, 1'b0);
        send_frame(8'hE0, 1'b0, -1, 11);
        send_frame(8'h74, 1'b0, -1, 11);
        tick(10);

        // Stall after 5 data bits, let the watchdog fire.
        send_frame(8'h55, 1'b0, -1, 6);
        check("stall_busy", {31'd0, busy}, 32'd1);
        tick(TO + 20);
        check("timeout_busy_low", {31'd0, busy}, 32'd0);
        check("timeout_frame_err", n_frm, 32'd1);
        push(8'h29, 1'b0, 1'b0);
        send_frame(8'h29, 1'b0, -1, 11);
        tick(10);

        // Overrun: second event dropped while the first is held.
        ev_ready = 1'b0;
        push(8'h1C, 1'b0, 1'b0);
        send_frame(8'h1C, 1'b0, -1, 11);
        send_frame(8'h32, 1'b0, -1, 11);
        tick(5);
        check("overrun_held_valid", {31'd0, ev_valid}, 32'd1);
        check("overrun_held_code", {24'd0, ev_code}, 32'h1C);
        check("overrun_pulses", n_ovr, 32'd1);
        ev_ready = 1'b1;
        tick(3);
        check("overrun_drained", {31'd0, ev_valid}, 32'd0);
        tick(10);

        // Short clock glitches in IDLE and mid-frame must be ignored.
        ps2_clk = 1'b0;
        tick(FILT - 1);
        ps2_clk = 1'b1;
        tick(20);
        check("idle_glitch_no_err", n_frm, 32'd1);
        check("idle_glitch_busy", {31'd0, busy}, 32'd0);
        push(8'h5A, 1'b0, 1'b0);
        send_frame(8'h5A, 1'b0, 3, 11);
        tick(10);
        check("data_glitch_errors", n_par + n_frm, 32'd2);

        check("scoreboard_empty", q.size(), 32'd0);
        check("overrun_total", n_ovr, 32'd1);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
